// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: operation encoding and FSM states.
// Optional macro ITER_SHIFTER_ROTATE_EN enables the rotate-right operation.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10,
        ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational step of the iterative shifter: shifts acc by k (0..STEP).
// ITER_SHIFTER_ROTATE_EN builds the rotate arm; without it mode ROR acts as SRL.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [KW-1:0]    k,
    input  shift_mode_t      mode,
    output logic [WIDTH-1:0] shifted
);

`ifdef ITER_SHIFTER_ROTATE_EN
    logic [2*WIDTH-1:0] w_rotWide;
    assign w_rotWide = {acc, acc} >> k;
`endif

    // Select the shift flavour; SRA fills from the accumulator MSB, which SRA never changes
    always_comb begin
        shifted = acc >> k;
        case (mode)
            SLL: shifted = acc << k;
            SRL: shifted = acc >> k;
            SRA: shifted = $signed(acc) >>> k;
`ifdef ITER_SHIFTER_ROTATE_EN
            ROR: shifted = w_rotWide[WIDTH-1:0];
`endif
            default: shifted = acc >> k;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: applies at most STEP bits of shift per clock behind a
// start/busy/done handshake. Optional macro ITER_SHIFTER_ROTATE_EN adds ROR (mode 11).
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH),
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [SHW:0] STEP_EXT = (SHW + 1)'(STEP);

    shift_state_t      r_state;
    shift_state_t      w_nextState;
    logic [WIDTH-1:0]  r_acc;
    logic [SHW-1:0]    r_rem;
    shift_mode_t       r_mode;
    logic [WIDTH-1:0]  r_result;
    logic              w_load;
    logic              w_stepActive;
    logic              w_finish;
    logic [SHW:0]      w_remExt;
    logic [KW-1:0]     w_k;
    logic [WIDTH-1:0]  w_stepped;

    assign w_remExt     = {1'b0, r_rem};
    assign w_k          = (w_remExt > STEP_EXT) ? KW'(STEP) : w_remExt[KW-1:0];
    assign w_stepActive = (r_state == SHIFT) && (r_rem != '0);
    assign w_finish     = (r_state == SHIFT) && (r_rem == '0);
    assign result       = r_result;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_shiftStep (
        .acc     (r_acc),
        .k       (w_k),
        .mode    (r_mode),
        .shifted (w_stepped)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs; start is only honoured in IDLE or DONE
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_rem == '0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Accumulator and remaining count: capture on accept, then walk down by k per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_rem  <= '0;
            r_mode <= SLL;
        end else if (w_load) begin
            r_acc  <= data_in;
            r_rem  <= shamt;
            r_mode <= shift_mode_t'(mode);
        end else if (w_stepActive) begin
            r_acc  <= w_stepped;
            r_rem  <= r_rem - SHW'(w_k);
        end
    end

    // Result register: updated only when the count reaches zero, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (w_finish) begin
            r_result <= r_acc;
        end
    end

endmodule
